ir_packet_tx_multi: RTL

//  Parametrised IR remote-car packet transmitter, successor to the single-colour blue transmitter.

---
 rtl/ir_packet_tx_multi.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/ir_packet_tx_multi.sv
// IR remote-car packet transmitter: four run-time selectable car colours, internal carrier,
// launch-time snapshot of command/colour and a one-deep pending send request.
//
// state | meaning
// IDLE  | waiting for a send request or a pending request
// BURST | LED follows the carrier for the current segment
// SPACE | LED held low for a gap segment
module ir_packet_tx_multi #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int NUM_CMD_BITS = 4,
  parameter int CNT_W        = 8,
  parameter int HALF_W       = 12
) (
  input  logic                    CLK,
  input  logic                    RESETN,
  input  logic                    SEND_PACKET,
  input  logic [1:0]              CAR_SEL,
  input  logic [NUM_CMD_BITS-1:0] COMMAND,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    IR_LED
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_SPACE = 2'd2;

  localparam int NUM_SEG = 4 + 2 * NUM_CMD_BITS;
  localparam int SEG_W   = $clog2(NUM_SEG);

  localparam int HALF_36K   = (CLK_FREQ + 36000) / (2 * 36000);
  localparam int HALF_40K   = (CLK_FREQ + 40000) / (2 * 40000);
  localparam int HALF_37K5  = (CLK_FREQ + 37500) / (2 * 37500);

  logic [1:0]              state_q, state_d;
  logic [SEG_W-1:0]        seg_q, seg_d;
  logic [CNT_W-1:0]        per_cnt_q, per_cnt_d;
  logic [HALF_W-1:0]       half_cnt_q, half_cnt_d;
  logic                    phase_q, phase_d;
  logic [1:0]              car_q, car_d;
  logic [NUM_CMD_BITS-1:0] cmd_q, cmd_d;
  logic                    pending_q, pending_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    ir_led_q, ir_led_d;

  logic [HALF_W-1:0] half_len;
  logic [CNT_W-1:0]  start_len, gap_len, carsel_len, assert_len, deassert_len, seg_len;
  logic              half_end, per_end, seg_end, last_seg;

  always_comb begin
    half_len     = HALF_W'(HALF_36K);
    start_len    = CNT_W'(191);
    gap_len      = CNT_W'(25);
    carsel_len   = CNT_W'(47);
    assert_len   = CNT_W'(47);
    deassert_len = CNT_W'(22);
    case (car_q)
      2'd1: begin
        half_len     = HALF_W'(HALF_40K);
        start_len    = CNT_W'(88);
        gap_len      = CNT_W'(40);
        carsel_len   = CNT_W'(22);
        assert_len   = CNT_W'(44);
        deassert_len = CNT_W'(22);
      end
      2'd2: begin
        half_len     = HALF_W'(HALF_37K5);
        start_len    = CNT_W'(88);
        gap_len      = CNT_W'(40);
        carsel_len   = CNT_W'(44);
        assert_len   = CNT_W'(44);
        deassert_len = CNT_W'(22);
      end
      2'd3: begin
        half_len     = HALF_W'(HALF_36K);
        start_len    = CNT_W'(192);
        gap_len      = CNT_W'(24);
        carsel_len   = CNT_W'(24);
        assert_len   = CNT_W'(48);
        deassert_len = CNT_W'(24);
      end
      default: ;
    endcase
  end

  // Odd segments are gaps; direction bits are consumed MSB first from a shifting copy.
  always_comb begin
    if (seg_q == '0)                 seg_len = start_len;
    else if (seg_q[0])               seg_len = gap_len;
    else if (seg_q == SEG_W'(2))     seg_len = carsel_len;
    else if (cmd_q[NUM_CMD_BITS-1])  seg_len = assert_len;
    else                             seg_len = deassert_len;
  end

  assign half_end = (half_cnt_q == half_len - HALF_W'(1));
  assign per_end  = half_end && !phase_q;
  assign seg_end  = per_end && (per_cnt_q == seg_len - CNT_W'(1));
  assign last_seg = (seg_q == SEG_W'(NUM_SEG - 1));

  always_comb begin
    state_d    = state_q;
    seg_d      = seg_q;
    per_cnt_d  = per_cnt_q;
    half_cnt_d = half_cnt_q;
    phase_d    = phase_q;
    car_d      = car_q;
    cmd_d      = cmd_q;
    pending_d  = pending_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ir_led_d   = 1'b0;

    if (SEND_PACKET && busy_q) pending_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (SEND_PACKET || pending_q) begin
          car_d      = CAR_SEL;
          cmd_d      = COMMAND;
          half_cnt_d = '0;
          phase_d    = 1'b1;
          per_cnt_d  = '0;
          seg_d      = '0;
          state_d    = S_BURST;
          busy_d     = 1'b1;
          ir_led_d   = 1'b1;
          pending_d  = 1'b0;
        end
      end
      S_BURST, S_SPACE: begin
        // Carrier runs free across segment boundaries.
        if (half_end) begin
          half_cnt_d = '0;
          phase_d    = !phase_q;
        end else begin
          half_cnt_d = half_cnt_q + HALF_W'(1);
        end
        if (per_end) per_cnt_d = per_cnt_q + CNT_W'(1);
        if (seg_end) begin
          per_cnt_d = '0;
          if (last_seg) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            seg_d   = seg_q + SEG_W'(1);
            state_d = (state_q == S_BURST) ? S_SPACE : S_BURST;
            if (state_q == S_BURST && seg_q >= SEG_W'(4)) cmd_d = cmd_q << 1;
          end
        end
        ir_led_d = (state_d == S_BURST) && phase_d;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= S_IDLE;
      seg_q      <= '0;
      per_cnt_q  <= '0;
      half_cnt_q <= '0;
      phase_q    <= 1'b0;
      car_q      <= 2'd0;
      cmd_q      <= '0;
      pending_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ir_led_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      seg_q      <= seg_d;
      per_cnt_q  <= per_cnt_d;
      half_cnt_q <= half_cnt_d;
      phase_q    <= phase_d;
      car_q      <= car_d;
      cmd_q      <= cmd_d;
      pending_q  <= pending_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ir_led_q   <= ir_led_d;
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign IR_LED = ir_led_q;

endmodule
